// File: rtl/c_result_drain.sv
// c_result_drain: drains completed C tiles from the inactive result bank.
// Each toggle of output_trigger_in starts a sequential read of all
// MEM_DEPTH entries; read data streams out through a credit-protected FIFO
// over a valid/ready interface with a last marker on the final entry.
// Optional: define C_DRAIN_TILE_ID_EN to add the tile_id_out counter port.
module c_result_drain #(
  parameter int D_WIDTH        = 64,
  parameter int A_PART_NUM_WTH = 1,
  parameter int B_NUM_WTH      = 1,
  parameter int RD_DELAY       = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                output_trigger_in,
  output logic                                res_rd_en_out,
  output logic [A_PART_NUM_WTH+B_NUM_WTH-1:0] res_rd_addr_out,
  input  logic [D_WIDTH-1:0]                  res_rd_data_in,
  output logic                                m_valid_out,
  input  logic                                m_ready_in,
  output logic [D_WIDTH-1:0]                  m_data_out,
  output logic                                m_last_out,
  output logic                                busy_out,
  output logic                                overrun_err_out
`ifdef C_DRAIN_TILE_ID_EN
  ,
  output logic [15:0]                         tile_id_out
`endif
);

  localparam int AW        = A_PART_NUM_WTH + B_NUM_WTH;
  localparam int MEM_DEPTH = 1 << AW;
  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int IW        = $clog2(RD_DELAY + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH} state_t;

  state_t              state;
  logic                trig_q;
  logic                pending;
  logic [AW-1:0]       addr;
  logic                toggle;
  logic                issue;
  logic                issue_last;
  logic                push;
  logic                pop;
  logic [31:0]         occupancy;

  logic [RD_DELAY-1:0] pipe_vld;
  logic [RD_DELAY-1:0] pipe_last;
  logic [IW-1:0]       inflight;

  logic [D_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  // Toggle detect, read-credit check and FIFO handshake decode
  always_comb begin
    toggle     = output_trigger_in ^ trig_q;
    occupancy  = 32'(count) + 32'(inflight);
    issue      = (state == S_READ) && (occupancy < 32'(FIFO_DEPTH));
    issue_last = issue && (addr == AW'(MEM_DEPTH - 1));
    push       = pipe_vld[RD_DELAY-1];
    pop        = (count != '0) && m_ready_in;
  end

  // Output decode; beat fields are forced to zero while no beat is presented
  always_comb begin
    res_rd_en_out   = issue;
    res_rd_addr_out = addr;
    m_valid_out     = (count != '0);
    m_data_out      = m_valid_out ? fifo_data[rd_ptr] : '0;
    m_last_out      = m_valid_out && fifo_last[rd_ptr];
    busy_out        = (state != S_IDLE);
  end

  // Drain control FSM with tile-overlap tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      trig_q          <= 1'b0;
      pending         <= 1'b0;
      addr            <= '0;
      overrun_err_out <= 1'b0;
    end else begin
      trig_q <= output_trigger_in;
      case (state)
        S_IDLE: begin
          if (toggle || pending) begin
            state   <= S_READ;
            addr    <= '0;
            // a fresh toggle coinciding with a queued tile stays queued
            pending <= toggle && pending;
          end
        end
        S_READ: begin
          if (issue_last) begin
            state <= S_FLUSH;
          end else if (issue) begin
            addr <= addr + 1'b1;
          end
        end
        default: begin
          // leave as the final beat hands off so busy drops right after it
          if (inflight == '0 && (count == '0 || (count == CW'(1) && pop))) begin
            state <= S_IDLE;
          end
        end
      endcase
      if (state != S_IDLE && toggle) begin
        if (pending) begin
          overrun_err_out <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

  // Read-latency tracking: one {valid,last} tag per issued read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      inflight  <= '0;
    end else begin
      for (int unsigned i = RD_DELAY - 1; i > 0; i--) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue_last;
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Output FIFO; credit on the read side guarantees it never overflows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= res_rd_data_in;
        fifo_last[wr_ptr] <= pipe_last[RD_DELAY-1];
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef C_DRAIN_TILE_ID_EN
  // Tile counter advances when the last beat of a tile is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_id_out <= '0;
    end else if (pop && fifo_last[rd_ptr]) begin
      tile_id_out <= tile_id_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_c_result_drain.sv
// tb_c_result_drain: scoreboard bench for c_result_drain (default parameters).
// Expected beats are queued when a tile trigger is driven and compared as
// the DUT hands beats off. Cycle r is counted from reset release.
module tb_c_result_drain;
  localparam int DW = 64;
  localparam int AW = 2;
  localparam int MD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          trig;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          overrun;
`ifdef C_DRAIN_TILE_ID_EN
  logic [15:0]   tile_id;
`endif

  c_result_drain #(
    .D_WIDTH(64), .A_PART_NUM_WTH(1), .B_NUM_WTH(1), .RD_DELAY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .output_trigger_in(trig),
    .res_rd_en_out(rd_en), .res_rd_addr_out(rd_addr), .res_rd_data_in(rd_data),
    .m_valid_out(m_valid), .m_ready_in(m_ready), .m_data_out(m_data),
    .m_last_out(m_last), .busy_out(busy), .overrun_err_out(overrun)
`ifdef C_DRAIN_TILE_ID_EN
    , .tile_id_out(tile_id)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  // SRAM model: word encodes salt and address, valid two cycles after the read
  logic [31:0]   salt = 32'h0;
  logic [AW-1:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    a1 <= rd_addr;
    a2 <= a1;
  end
  assign rd_data = {salt, 30'h0, a2};

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;
  beat_t exp_q[$];

  function automatic beat_t mk(input int i);
    beat_t b;
    b.data = {salt, 30'h0, AW'(i)};
    b.last = (i == MD - 1);
    return b;
  endfunction

  task automatic push_tile();
    for (int i = 0; i < MD; i++) exp_q.push_back(mk(i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    trig = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trig = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({rd_en, m_valid, m_last, busy, overrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {rd_en, m_valid, m_last, busy, overrun});
    end
    n_tests++;
    if (m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h expected 0", m_data);
    end
`ifdef C_DRAIN_TILE_ID_EN
    n_tests++;
    if (tile_id !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_tile_id: got %0d expected 0", tile_id);
    end
`endif
  endtask

  task automatic test_basic();
    int r;
    beat_t e;
    do_reset();
    salt = 32'h0001_0000;
    m_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      r = cyc - base;
      if (r == 10) begin trig = ~trig; push_tile(); end
      @(negedge clk);
      n_tests++;
      if (rd_en !== (r >= 11 && r <= 14)) begin
        n_fail++; $display("FAIL basic_rd_en c%0d: got %b expected %b", r, rd_en, (r >= 11 && r <= 14));
      end
      if (r >= 11 && r <= 14) begin
        n_tests++;
        if (rd_addr !== AW'(r - 11)) begin
          n_fail++; $display("FAIL basic_addr c%0d: got %0d expected %0d", r, rd_addr, r - 11);
        end
      end
      n_tests++;
      if (m_valid !== (r >= 14 && r <= 17)) begin
        n_fail++; $display("FAIL basic_valid c%0d: got %b expected %b", r, m_valid, (r >= 14 && r <= 17));
      end
      n_tests++;
      if (m_last !== (r == 17)) begin
        n_fail++; $display("FAIL basic_last c%0d: got %b expected %b", r, m_last, (r == 17));
      end
      n_tests++;
      if (busy !== (r >= 11 && r <= 17)) begin
        n_fail++; $display("FAIL basic_busy c%0d: got %b expected %b", r, busy, (r >= 11 && r <= 17));
      end
      if (m_valid && m_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (m_data !== e.data) begin
          n_fail++; $display("FAIL basic_data c%0d: got %0h expected %0h", r, m_data, e.data);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_beats_left: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int r;
    int nrd = 0;
    logic hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic hold_l = 1'b0;
    beat_t e;
    do_reset();
    salt = 32'h0002_0000;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      r = cyc - base;
      if (r == 10) begin trig = ~trig; push_tile(); end
      if (r == 30) m_ready = 1'b1;
      @(negedge clk);
      if (rd_en) nrd++;
      if (r == 29) begin
        n_tests++;
        if (m_valid !== 1'b1) begin
          n_fail++; $display("FAIL bp_valid_stalled: got %b expected 1", m_valid);
        end
      end
      if (m_valid && !m_ready) begin
        if (hold_v) begin
          n_tests++;
          if (m_data !== hold_d || m_last !== hold_l) begin
            n_fail++; $display("FAIL bp_hold c%0d: got %0h/%b expected %0h/%b", r, m_data, m_last, hold_d, hold_l);
          end
        end
        hold_v = 1'b1; hold_d = m_data; hold_l = m_last;
      end else begin
        hold_v = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL bp_extra_beat c%0d: got beat expected none", r);
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if ({m_data, m_last} !== {e.data, e.last}) begin
            n_fail++; $display("FAIL bp_beat c%0d: got %0h/%b expected %0h/%b", r, m_data, m_last, e.data, e.last);
          end
        end
      end
    end
    n_tests++;
    if (nrd != MD) begin
      n_fail++; $display("FAIL bp_reads: got %0d expected %0d", nrd, MD);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_beats_left: got %0d expected 0", exp_q.size());
    end
  endtask

  // toggles lists trigger cycles; ntiles tiles are expected to be drained
  task automatic run_tiles(input string name, input int t0, input int t1, input int t2,
                           input int ntiles, input int overrun_at, input int cycles);
    int r;
    int nbeats = 0;
    int pushed = 0;
    logic [15:0] exp_id = 16'd0;
    beat_t e;
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      r = cyc - base;
      if (r == t0 || r == t1 || r == t2) begin
        trig = ~trig;
        if (pushed < ntiles) begin push_tile(); pushed++; end
      end
      @(negedge clk);
      n_tests++;
      if (overrun !== (overrun_at > 0 && r >= overrun_at)) begin
        n_fail++; $display("FAIL %s_overrun c%0d: got %b expected %b", name, r, overrun, (overrun_at > 0 && r >= overrun_at));
      end
      if (m_valid && m_ready) begin
        nbeats++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL %s_extra_beat c%0d: got beat expected none", name, r);
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if ({m_data, m_last} !== {e.data, e.last}) begin
            n_fail++; $display("FAIL %s_beat c%0d: got %0h/%b expected %0h/%b", name, r, m_data, m_last, e.data, e.last);
          end
`ifdef C_DRAIN_TILE_ID_EN
          n_tests++;
          if (tile_id !== exp_id) begin
            n_fail++; $display("FAIL %s_tile_id c%0d: got %0d expected %0d", name, r, tile_id, exp_id);
          end
`endif
          if (e.last) exp_id = exp_id + 16'd1;
        end
      end
    end
    n_tests++;
    if (nbeats != ntiles * MD) begin
      n_fail++; $display("FAIL %s_beat_count: got %0d expected %0d", name, nbeats, ntiles * MD);
    end
`ifdef C_DRAIN_TILE_ID_EN
    n_tests++;
    if (tile_id !== exp_id) begin
      n_fail++; $display("FAIL %s_tile_id_end: got %0d expected %0d", name, tile_id, exp_id);
    end
`endif
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_end: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_back_to_back();
    salt = 32'h0003_0000;
    run_tiles("b2b", 10, 12, -1, 2, 0, 45);
  endtask

  task automatic test_overrun();
    salt = 32'h0004_0000;
    run_tiles("ovr", 10, 12, 13, 2, 14, 45);
  endtask

  task automatic test_tile_id();
    salt = 32'h0006_0000;
    run_tiles("tid", 10, 12, 30, 3, 0, 60);
  endtask

  task automatic test_reset_mid();
    int r;
    beat_t e;
    do_reset();
    salt = 32'h0005_0000;
    m_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      r = cyc - base;
      if (r == 10) begin trig = ~trig; push_tile(); end
      if (r == 13) begin
        rst = 1'b1; trig = 1'b0; exp_q.delete();
        #1;
        n_tests++;
        if ({rd_en, m_valid, m_last, busy, overrun} !== 5'b0 || m_data !== '0) begin
          n_fail++; $display("FAIL rmid_outputs: got %b/%0h expected 00000/0", {rd_en, m_valid, m_last, busy, overrun}, m_data);
        end
      end
      if (r == 16) rst = 1'b0;
      if (r == 31) begin trig = ~trig; push_tile(); end
      @(negedge clk);
      if (r >= 13 && r <= 31) begin
        n_tests++;
        if ({rd_en, m_valid, busy} !== 3'b0) begin
          n_fail++; $display("FAIL rmid_quiet c%0d: got %b expected 000", r, {rd_en, m_valid, busy});
        end
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL rmid_extra_beat c%0d: got beat expected none", r);
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if ({m_data, m_last} !== {e.data, e.last}) begin
            n_fail++; $display("FAIL rmid_beat c%0d: got %0h/%b expected %0h/%b", r, m_data, m_last, e.data, e.last);
          end
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rmid_beats_left: got %0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    trig = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`ifdef C_DRAIN_TILE_ID_EN
    test_tile_id();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
